// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size encodings,
// control state machine states and the default data memory depth.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int DEPTH_DEFAULT = 1024;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RMW_RD = 3'd2,
        WR     = 3'd3,
        RSP    = 3'd4
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane handling: extracts and extends a load lane, and merges
// store data into an old memory word for sub-word writes.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] ld_word_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ext_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane extract with sign or zero extension
    always_comb begin
        byte_s = ld_word_i[{lane_i, 3'b000} +: 8];
        half_s = ld_word_i[{lane_i[1], 4'b0000} +: 16];
        case (size_i)
            SZ_BYTE: ext_o = {{24{~unsigned_i & byte_s[7]}}, byte_s};
            SZ_HALF: ext_o = {{16{~unsigned_i & half_s[15]}}, half_s};
            default: ext_o = ld_word_i;
        endcase
    end

    // Store merge: only the addressed lane takes new data
    always_comb begin
        merged_o = old_word_i;
        case (size_i)
            SZ_BYTE: merged_o[{lane_i, 3'b000} +: 8]    = wdata_i[7:0];
            SZ_HALF: merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: merged_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed execute-stage requests into accesses
// to a word-addressed data memory, with read-modify-write for sub-word stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic [31:0]   mem_a,
    output logic          mem_we,
    output logic [31:0]   mem_wd,
    output logic          mem_sel,
    input  logic [31:0]   mem_rd
);

    localparam logic [AW-3:0] DEPTH_W = (AW-2)'(DEPTH);

    lsu_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    size_q, size_d;
    logic          we_q, we_d;
    logic          uns_q, uns_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   merge_q, merge_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          req_err_s;
    logic [31:0]   ext_s;
    logic [31:0]   merged_s;

    lsu_align u_align (
        .lane_i     (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .ld_word_i  (mem_rd),
        .old_word_i (merge_q),
        .wdata_i    (wdata_q),
        .ext_o      (ext_s),
        .merged_o   (merged_s)
    );

    // Request legality: size, alignment and word index range
    always_comb begin
        case (req_size)
            SZ_BYTE: req_err_s = 1'b0;
            SZ_HALF: req_err_s = req_addr[0];
            SZ_WORD: req_err_s = (req_addr[1:0] != 2'b00);
            default: req_err_s = 1'b1;
        endcase
        req_err_s = req_err_s | (req_addr[AW-1:2] >= DEPTH_W);
    end

    // Next-state and capture logic; response fields only change on entry to RSP
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        we_d    = we_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    we_d    = req_we;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    if (req_err_s) begin
                        state_d = RSP;
                        rdata_d = 32'h0000_0000;
                        err_d   = 1'b1;
                    end else if (!req_we) begin
                        state_d = RD;
                    end else if (req_size == SZ_WORD) begin
                        state_d = WR;
                    end else begin
                        state_d = RMW_RD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD: begin
                state_d = RSP;
                rdata_d = ext_s;
                err_d   = 1'b0;
            end
            RMW_RD: begin
                state_d = WR;
                merge_d = mem_rd;
            end
            WR: begin
                state_d = RSP;
                rdata_d = 32'h0000_0000;
                err_d   = 1'b0;
            end
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and capture registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= 2'b00;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= 32'h0000_0000;
            merge_q <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Memory strobes come from the state register alone so reset kills them at once
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RSP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_sel   = (state_q == RD) || (state_q == RMW_RD) || (state_q == WR);
    assign mem_we    = (state_q == WR);
    assign mem_wd    = (state_q == WR) ? merged_s : 32'h0000_0000;
    assign mem_a     = 32'(addr_q[AW-1:2]);

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit with a behavioural
// memory and a reference model of the load/store rules.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we, mem_sel;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        bd_we = 1'b0;
    logic [9:0]  bd_idx = 10'd0;
    logic [31:0] bd_data = 32'h0;

    int n_vec = 0;
    int n_err = 0;
    int we_cnt = 0, sel_cnt = 0, acc_cnt = 0, b2b_cnt = 0;
    logic prev_rsp = 1'b0;

    load_store_unit #(.DEPTH(1024), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd),
        .mem_sel(mem_sel), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = (mem_sel && !mem_we) ? mem[mem_a[9:0]] : 32'h0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        else if (mem_sel && mem_we) mem[mem_a[9:0]] <= mem_wd;
    end

    always @(posedge clk) begin
        if (req_valid && req_ready && !rst) acc_cnt <= acc_cnt + 1;
    end

    always @(negedge clk) begin
        if (mem_we) we_cnt <= we_cnt + 1;
        if (mem_sel) sel_cnt <= sel_cnt + 1;
        if (rsp_valid && prev_rsp) b2b_cnt <= b2b_cnt + 1;
        prev_rsp <= rsp_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bd_write(input int idx, input logic [31:0] data);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = 10'(idx); bd_data = data;
        @(negedge clk);
        bd_we = 1'b0;
        ref_mem[idx] = data;
    endtask

    // Reference model: applies one request to ref_mem and predicts the response
    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic err, output logic [31:0] rdata,
                         output int lat, output int nwe, output int nsel);
        int unsigned idx, lane, sh;
        logic [31:0] w, mask, v;
        idx  = addr / 4;
        lane = addr % 4;
        err  = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
               (size == 2'd2 && lane != 0) || (idx >= 1024);
        rdata = 32'h0; lat = 1; nwe = 0; nsel = 0;
        if (!err) begin
            w = ref_mem[idx];
            if (size == 2'd0) begin sh = 8 * lane;        mask = 32'hFF;   end
            else if (size == 2'd1) begin sh = 16 * (lane / 2); mask = 32'hFFFF; end
            else begin sh = 0; mask = 32'hFFFF_FFFF; end
            if (!we) begin
                v = (w >> sh) & mask;
                if (!uns && size == 2'd0 && v >= 32'd128)   v = v + 32'hFFFF_FF00;
                if (!uns && size == 2'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
                rdata = v; lat = 2; nsel = 1;
            end else begin
                ref_mem[idx] = (w & ~(mask << sh)) | ((wdata & mask) << sh);
                nwe = 1;
                lat  = (size == 2'd2) ? 2 : 3;
                nsel = (size == 2'd2) ? 1 : 2;
            end
        end
    endtask

    task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input bit keep);
        logic e_err; logic [31:0] e_rdata; int e_lat, e_we, e_sel, we0, sel0, lat;
        int unsigned idx;
        idx = addr / 4;
        model(we, size, uns, addr, wdata, e_err, e_rdata, e_lat, e_we, e_sel);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        chk("ready", 32'(req_ready), 32'd1);
        we0 = we_cnt; sel0 = sel_cnt;
        @(posedge clk);
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(e_lat));
        chk("rdata", rsp_rdata, e_rdata);
        chk("err", 32'(rsp_err), 32'(e_err));
        chk("we_cycles", 32'(we_cnt - we0), 32'(e_we));
        chk("sel_cycles", 32'(sel_cnt - sel0), 32'(e_sel));
        if (!e_err) chk("mem_word", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int a0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_sel_we", {30'd0, mem_sel, mem_we}, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) bd_write(i, $urandom);
        bd_write(1, 32'd5);
        bd_write(4, 32'h1122_3344);

        run_op(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 1'b0);
        run_op(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AB, 1'b0);
        chk("byte_store_word4", mem[4], 32'h1122_AB44);
        run_op(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b0);
        chk("lb_signed", rsp_rdata, 32'hFFFF_FFAB);
        run_op(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 1'b0);
        run_op(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b0);
        chk("lh_signed", rsp_rdata, 32'h0000_1122);

        run_op(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 1'b0);
        run_op(1'b1, 2'd1, 1'b0, 32'h3, 32'hDEAD_BEEF, 1'b0);
        run_op(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 1'b0);
        run_op(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 1'b0);

        // Reset while the byte store is in its read half
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0000_00CD;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rmw_rd_sel", 32'(mem_sel), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_sel", 32'(mem_sel), 32'd0);
        chk("rst_mid_we", 32'(mem_we), 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_word4", mem[4], ref_mem[4]);
        run_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);

        // Continuous valid with alternating stores and loads
        a0 = acc_cnt;
        for (int i = 0; i < 10; i++) begin
            run_op((i % 2) == 0, 2'($urandom_range(0, 2)), 1'($urandom),
                   32'($urandom_range(0, 7) * 4), $urandom, 1'b1);
        end
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("accept_count", 32'(acc_cnt - a0), 32'd10);

        for (int i = 0; i < 80; i++) begin
            logic [31:0] addr;
            addr = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) addr = 32'h1000 + 32'($urandom_range(0, 4095));
            run_op(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), addr, $urandom, 1'b0);
        end

        chk("rsp_back_to_back", 32'(b2b_cnt), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
